intmul_varlat_iter: RTL and testbench

Iterative, variable-latency signed integer multiplier. It is the responder side of the val_op / oprand_rdy / commit operand-result protocol that our multiplier test sources and sinks drive.
- Accepts one 32x32 operand pair at a time.
- Runs a shift-add datapath, one multiplier bit per cycle, or faster with zero-skip enabled.
- Returns a 64-bit product with a single-cycle commit pulse.
- Drop-in alternative to the pipelined multiplier behind the same bench.

---
 rtl/intmul_pkg.sv | 20 ++
 rtl/intmul_varlat_dpath.sv | 74 +++++++
 rtl/intmul_varlat_iter.sv | 106 ++++++++++
 tb/tb_intmul_varlat_iter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/intmul_pkg.sv
// Shared constants and encodings for the iterative signed multiplier.
package intmul_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SKIP_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Kind of work the datapath asks for in the current CALC cycle.
  typedef enum logic [1:0] {
    STEP_BIT  = 2'd0,
    STEP_SKIP = 2'd1,
    STEP_STOP = 2'd2
  } step_t;

endpackage

// File: rtl/intmul_varlat_dpath.sv
// Magnitude shift-add datapath with sign fix-up of the final product.
// INTMUL_ZERO_SKIP_EN: enables zero-nibble skip and early stop when b runs out.
module intmul_varlat_dpath
  import intmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_iter,
  input  logic               i_skip,
  input  logic               i_finish,
  input  logic [WIDTH-1:0]   i_op_a,
  input  logic [WIDTH-1:0]   i_op_b,
  output logic [1:0]         o_step,
  output logic [2*WIDTH-1:0] o_prod
);

  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign w_mag_a    = i_op_a[WIDTH-1] ? -i_op_a : i_op_a;
  assign w_mag_b    = i_op_b[WIDTH-1] ? -i_op_b : i_op_b;
  assign w_acc_next = (i_iter && r_b[0]) ? r_acc + r_a : r_acc;
  assign o_prod     = r_prod;

  always_comb begin
    o_step = STEP_BIT;
`ifdef INTMUL_ZERO_SKIP_EN
    if (r_b == '0) begin
      o_step = STEP_STOP;
    end else if (r_b[SKIP_BITS-1:0] == '0) begin
      o_step = STEP_SKIP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_neg  <= 1'b0;
      r_prod <= '0;
    end else begin
      if (i_load) begin
        r_a   <= {{WIDTH{1'b0}}, w_mag_a};
        r_b   <= w_mag_b;
        r_acc <= '0;
        r_neg <= i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1];
      end else if (i_iter) begin
        r_acc <= w_acc_next;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
      end else if (i_skip) begin
        r_a <= r_a << SKIP_BITS;
        r_b <= r_b >> SKIP_BITS;
      end
      // Product is captured on the edge entering DONE so it is valid during commit.
      if (i_finish) begin
        r_prod <= r_neg ? -w_acc_next : w_acc_next;
      end
    end
  end

endmodule

// File: rtl/intmul_varlat_iter.sv
// Iterative signed multiplier: operand handshake, iteration FSM and count.
// Latency depends on INTMUL_ZERO_SKIP_EN (see datapath); products do not.
//
// state | meaning
// IDLE  | ready for an operand pair
// CALC  | one shift-add (or skip) step per cycle
// DONE  | commit pulse, longP carries the new product
module intmul_varlat_iter
  import intmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   intA,
  input  logic [WIDTH-1:0]   intB,
  input  logic               val_op,
  output logic               oprand_rdy,
  output logic [2*WIDTH-1:0] longP,
  output logic               commit
);

  localparam int                CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SKIP  = CNT_W'(SKIP_BITS);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_load;
  logic             w_iter;
  logic             w_skip;
  logic             w_finish;
  logic [1:0]       w_step;

  intmul_varlat_dpath #(.WIDTH(WIDTH)) u_dpath (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_iter   (w_iter),
    .i_skip   (w_skip),
    .i_finish (w_finish),
    .i_op_a   (intA),
    .i_op_b   (intB),
    .o_step   (w_step),
    .o_prod   (longP)
  );

  assign oprand_rdy = !reset && (r_state == IDLE);
  assign commit     = !reset && (r_state == DONE);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_load       = 1'b0;
    w_iter       = 1'b0;
    w_skip       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (val_op) begin
          w_load       = 1'b1;
          w_count_next = '0;
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (w_step == STEP_STOP) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end else begin
          if (w_step == STEP_SKIP) begin
            w_skip       = 1'b1;
            w_count_next = r_count + CNT_SKIP;
          end else begin
            w_iter       = 1'b1;
            w_count_next = r_count + CNT_ONE;
          end
          if (w_count_next >= CNT_MAX) begin
            w_finish     = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_intmul_varlat_iter.sv
// Scoreboard bench: driver pushes expected product/latency, monitor checks on commit.
module tb_intmul_varlat_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        val_op = 1'b0;
  logic [31:0] intA = '0;
  logic [31:0] intB = '0;
  logic        oprand_rdy;
  logic        commit;
  logic [63:0] longP;

  always #5 clk = ~clk;

  intmul_varlat_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .intA       (intA),
    .intB       (intB),
    .val_op     (val_op),
    .oprand_rdy (oprand_rdy),
    .longP      (longP),
    .commit     (commit)
  );

  typedef struct {
    logic [63:0] p;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   commits = 0;
  int   pushes = 0;
  bit   chk_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected cycle index of the commit, counting the accept cycle as 0.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef INTMUL_ZERO_SKIP_EN
    logic [31:0] m;
    int n;
    int cnt;
    m = b[31] ? -b : b;
    n = 0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      n++;
      if (m == 0) break;
      if (m[3:0] == 4'h0) begin
        m = m >> 4;
        cnt += 4;
      end else begin
        m = m >> 1;
        cnt += 1;
      end
      if (cnt >= 32) break;
    end
    return n + 1;
`else
    return 33;
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                       input bit push, input bit keep, input bit scramble, output int acc_cyc);
    int t;
    t = 0;
    @(negedge clk);
    intA = a;
    intB = b;
    val_op = 1'b1;
    while (!oprand_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    if (!oprand_rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: oprand_rdy stayed 0 for %0d cycles, expected 1", t);
      val_op = 1'b0;
      return;
    end
    if (push) begin
      sb.push_back('{p, cyc, exp_lat(b)});
      pushes++;
    end
    @(posedge clk);
    #1;
    if (!keep) val_op = 1'b0;
    if (scramble) begin
      intA = ~a;
      intB = b ^ 32'hFFFF0000;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        check("rdy_after_commit", {63'd0, oprand_rdy}, 64'd1);
        chk_rdy = 0;
      end
      if (commit) begin
        commits++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: longP=%h with no operation outstanding", longP);
        end else begin
          mon_e = sb.pop_front();
          check("product", longP, mon_e.p);
          check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          chk_rdy = 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, dummy, t;
    logic [31:0] ra, rb;
    longint sa, sbv;
    logic [63:0] rp;

    repeat (10) begin
      @(negedge clk);
      check("rdy_in_reset", {63'd0, oprand_rdy}, 64'd0);
    end
    check("commit_in_reset", {63'd0, commit}, 64'd0);
    check("longP_in_reset", longP, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", {63'd0, oprand_rdy}, 64'd1);

    issue(32'd3, 32'd4, 64'd12, 1, 0, 0, dummy);
    issue(32'd0, 32'd0, 64'd0, 1, 0, 0, dummy);
    issue(32'hFFFFFFFF, 32'd1, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, dummy);
    issue(32'h80000000, 32'h80000000, 64'h4000000000000000, 1, 0, 0, dummy);
    issue(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1, 0, 0, dummy);
    issue(32'h0000FFFF, 32'h00010000, 64'h00000000FFFF0000, 1, 0, 0, dummy);
    issue(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFFFFFFFFD6, 1, 0, 0, dummy);
    issue(32'd1, 32'h80000000, 64'hFFFFFFFF80000000, 1, 0, 0, dummy);

    issue(32'h00001234, 32'h00000010, 64'h0000000000012340, 1, 0, 1, dummy);

    issue(32'd2, 32'd3, 64'd6, 1, 1, 0, c0);
    issue(32'hFFFFFFFC, 32'd5, 64'hFFFFFFFFFFFFFFEC, 1, 1, 0, c1);
    issue(32'd100, 32'd100, 64'd10000, 1, 0, 0, c2);
    check("accept_gap1", 64'(c1 - c0), 64'(exp_lat(32'd3) + 1));
    check("accept_gap2", 64'(c2 - c1), 64'(exp_lat(32'd5) + 1));

    issue(32'd5, 32'd0, 64'd0, 1, 0, 0, dummy);
    issue(32'hFFFFFFFD, 32'd1, 64'hFFFFFFFFFFFFFFFD, 1, 0, 0, dummy);
    issue(32'd5, 32'h00000010, 64'h0000000000000050, 1, 0, 0, dummy);
    issue(32'd3, 32'h80000000, 64'hFFFFFFFE80000000, 1, 0, 0, dummy);

    issue(32'h00001234, 32'h7FFFFFFF, 64'd0, 0, 0, 0, dummy);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rdy_mid_reset", {63'd0, oprand_rdy}, 64'd0);
    check("commit_mid_reset", {63'd0, commit}, 64'd0);
    check("longP_mid_reset", longP, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_abort", {63'd0, oprand_rdy}, 64'd1);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = $signed(ra);
      sbv = $signed(rb);
      rp = sa * sbv;
      issue(ra, rb, rp, 1, 0, 0, dummy);
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("queue_drained", 64'(sb.size()), 64'd0);
    check("commit_count", 64'(commits), 64'(pushes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
